// File: rtl/pg_flr_pkg.sv
//------------------------------------------------------------------------------
// Module  : pg_flr_pkg
// Brief   : Shared types and helpers for the port-gasket FLR sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pg_flr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      RESET = 2'd2,
      DONE  = 2'd3
   } t_flr_state;

   localparam int PF_MAX_W = 8;
   localparam int VF_MAX_W = 16;

   typedef struct packed {
      logic [PF_MAX_W-1:0] pf;
      logic [VF_MAX_W-1:0] vf;
      logic                vf_active;
   } t_flr_req;

   // Counter must reach the larger of the reset hold and drain timeout
   function automatic int cnt_width(input int hold, input int timeout);
      int m;
      m = (hold > timeout) ? hold : timeout;
      return $clog2(m + 1);
   endfunction

   localparam int CNT_W = cnt_width(16, 4096);

   function automatic logic port_match(input int unsigned pf,
                                       input int unsigned vf,
                                       input logic        vf_active,
                                       input int unsigned num_ports,
                                       input logic        vf_mode);
      if (vf_mode)
         return vf_active && (pf == 0) && (vf < num_ports);
      else
         return !vf_active && (pf == 1);
   endfunction

   function automatic int unsigned port_index(input int unsigned vf,
                                              input logic        vf_mode);
      return vf_mode ? vf : 0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pg_flr_sequencer.sv
//------------------------------------------------------------------------------
// Module  : pg_flr_sequencer
// Brief   : Accepts one FLR at a time, drains and resets the mapped port-gasket
//           port, then returns an FLR-done handshake.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pg_flr_sequencer
   import pg_flr_pkg::*;
#(
   parameter int NUM_PORTS       = 4,
   parameter bit PG_VF_MODE      = 1'b1,
   parameter int PF_W            = 3,
   parameter int VF_W            = 11,
   parameter int RST_HOLD        = 16,
   parameter int QUIESCE_TIMEOUT = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flr_req_valid,
   output logic                 flr_req_ready,
   input  logic [PF_W-1:0]      flr_req_pf,
   input  logic [VF_W-1:0]      flr_req_vf,
   input  logic                 flr_req_vf_active,
   input  logic [NUM_PORTS-1:0] port_quiesced,
   output logic [NUM_PORTS-1:0] port_blk,
   output logic [NUM_PORTS-1:0] port_rst,
   output logic                 flr_done_valid,
   input  logic                 flr_done_ready,
   output logic [PF_W-1:0]      flr_done_pf,
   output logic [VF_W-1:0]      flr_done_vf,
   output logic                 flr_done_vf_active,
   output logic                 flr_timeout
);

   localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CNT_WIDTH = cnt_width(RST_HOLD, QUIESCE_TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] C_DRAIN_LAST = CNT_WIDTH'(QUIESCE_TIMEOUT - 1);
   localparam logic [CNT_WIDTH-1:0] C_HOLD_LAST  = CNT_WIDTH'(RST_HOLD - 1);

   t_flr_state             r_state, w_state_nxt;
   logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_nxt;
   logic [PORT_W-1:0]      r_port, w_port_nxt;
   logic [PF_W-1:0]        r_req_pf, w_req_pf_nxt;
   logic [VF_W-1:0]        r_req_vf, w_req_vf_nxt;
   logic                   r_req_vf_active, w_req_vf_active_nxt;

   logic [NUM_PORTS-1:0]   r_port_blk, w_port_blk_nxt;
   logic [NUM_PORTS-1:0]   r_port_rst, w_port_rst_nxt;
   logic                   r_done_valid, w_done_valid_nxt;
   logic [PF_W-1:0]        r_done_pf, w_done_pf_nxt;
   logic [VF_W-1:0]        r_done_vf, w_done_vf_nxt;
   logic                   r_done_vf_active, w_done_vf_active_nxt;
   logic                   r_timeout, w_timeout_nxt;

   logic                   w_accept;
   logic                   w_match;
   logic [PORT_W-1:0]      w_dec_port;
   logic                   w_quiesced;
   logic [NUM_PORTS-1:0]   w_sel_nxt;

   assign flr_req_ready = (r_state == IDLE);
   assign w_accept      = flr_req_valid && (r_state == IDLE);
   assign w_match       = port_match(32'(flr_req_pf), 32'(flr_req_vf), flr_req_vf_active,
                                     NUM_PORTS, PG_VF_MODE);
   assign w_dec_port    = PORT_W'(port_index(32'(flr_req_vf), PG_VF_MODE));
   // Only the latched port's quiesce bit matters
   assign w_quiesced    = |(port_quiesced & (NUM_PORTS'(1) << r_port));

   always_comb begin
      w_state_nxt         = r_state;
      w_cnt_nxt           = r_cnt;
      w_port_nxt          = r_port;
      w_req_pf_nxt        = r_req_pf;
      w_req_vf_nxt        = r_req_vf;
      w_req_vf_active_nxt = r_req_vf_active;
      w_timeout_nxt       = 1'b0;

      case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            if (w_accept) begin
               w_req_pf_nxt        = flr_req_pf;
               w_req_vf_nxt        = flr_req_vf;
               w_req_vf_active_nxt = flr_req_vf_active;
               if (w_match) begin
                  w_port_nxt  = w_dec_port;
                  w_state_nxt = DRAIN;
               end else begin
                  w_state_nxt = DONE;
               end
            end
         end
         DRAIN: begin
            if (w_quiesced) begin
               w_state_nxt = RESET;
               w_cnt_nxt   = '0;
            end else if (r_cnt == C_DRAIN_LAST) begin
               w_state_nxt   = RESET;
               w_cnt_nxt     = '0;
               w_timeout_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
            end
         end
         RESET: begin
            if (r_cnt == C_HOLD_LAST) begin
               w_state_nxt = DONE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
            end
         end
         DONE: begin
            if (flr_done_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase

      // Registered outputs are derived from the state being entered
      w_sel_nxt            = NUM_PORTS'(1) << w_port_nxt;
      w_port_blk_nxt       = ((w_state_nxt == DRAIN) || (w_state_nxt == RESET)) ? w_sel_nxt : '0;
      w_port_rst_nxt       = (w_state_nxt == RESET) ? w_sel_nxt : '0;
      w_done_valid_nxt     = (w_state_nxt == DONE);
      w_done_pf_nxt        = w_done_valid_nxt ? w_req_pf_nxt : '0;
      w_done_vf_nxt        = w_done_valid_nxt ? w_req_vf_nxt : '0;
      w_done_vf_active_nxt = w_done_valid_nxt && w_req_vf_active_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= IDLE;
         r_cnt            <= '0;
         r_port           <= '0;
         r_req_pf         <= '0;
         r_req_vf         <= '0;
         r_req_vf_active  <= 1'b0;
         r_port_blk       <= '0;
         r_port_rst       <= '0;
         r_done_valid     <= 1'b0;
         r_done_pf        <= '0;
         r_done_vf        <= '0;
         r_done_vf_active <= 1'b0;
         r_timeout        <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_cnt            <= w_cnt_nxt;
         r_port           <= w_port_nxt;
         r_req_pf         <= w_req_pf_nxt;
         r_req_vf         <= w_req_vf_nxt;
         r_req_vf_active  <= w_req_vf_active_nxt;
         r_port_blk       <= w_port_blk_nxt;
         r_port_rst       <= w_port_rst_nxt;
         r_done_valid     <= w_done_valid_nxt;
         r_done_pf        <= w_done_pf_nxt;
         r_done_vf        <= w_done_vf_nxt;
         r_done_vf_active <= w_done_vf_active_nxt;
         r_timeout        <= w_timeout_nxt;
      end
   end

   assign port_blk           = r_port_blk;
   assign port_rst           = r_port_rst;
   assign flr_done_valid     = r_done_valid;
   assign flr_done_pf        = r_done_pf;
   assign flr_done_vf        = r_done_vf;
   assign flr_done_vf_active = r_done_vf_active;
   assign flr_timeout        = r_timeout;

endmodule

`default_nettype wire
